// File: rtl/chaos_diffusion_stream_pkg.sv
// Shared types and the modular-reduction helper for the chaos diffusion stream engine.
package chaos_pkg;

  typedef enum logic {MODE_DEC = 1'b0, MODE_ENC = 1'b1} mode_e;
  typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

  // Valid only for x < 4*f: at most three subtractions bring the value below f
  function automatic logic [31:0] mod_reduce(input logic [31:0] x, input logic [31:0] f);
    logic [31:0] r;
    r = x;
    for (int i = 0; i < 3; i++) begin
      if (r >= f) r = r - f;
    end
    return r;
  endfunction

endpackage

// File: rtl/chaos_diffusion_stream_if.sv
// Pixel stream bundle: input stream (s_*) and output stream with raster flags (m_*).
interface chaos_diffusion_stream_if #(parameter int DW = 8);
  logic          s_valid;
  logic          s_ready;
  logic [DW-1:0] s_data;
  logic          m_valid;
  logic          m_ready;
  logic [DW-1:0] m_data;
  logic          m_sof;
  logic          m_eol;
  logic          m_eof;

  modport slave (
    input  s_valid, s_data, m_ready,
    output s_ready, m_valid, m_data, m_sof, m_eol, m_eof
  );

  modport master (
    output s_valid, s_data, m_ready,
    input  s_ready, m_valid, m_data, m_sof, m_eol, m_eof
  );
endinterface

// File: rtl/chaos_diffusion_stream_line_buf.sv
// One-row reference store: combinational read-first, synchronous write at the same address.
module diffusion_line_buf #(
  parameter int DEPTH = 256,
  parameter int DW    = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] addr,
  input  logic [DW-1:0] wdata,
  output logic [DW-1:0] rdata
);

  // Contents only matter from row 1 onwards, so the array is deliberately not reset
  logic [DW-1:0] mem [DEPTH];

  assign rdata = mem[addr];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

endmodule

// File: rtl/chaos_diffusion_stream.sv
// Streaming modular diffusion (encrypt) / inverse diffusion (decrypt), one pixel per clock.
module chaos_diffusion_stream
  import chaos_pkg::*;
#(
  parameter int PIX_W    = 8,
  parameter int CHANNELS = 1,
  parameter int IMG_W    = 256,
  parameter int IMG_H    = 256
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cfg_mode,
  input  logic [PIX_W-1:0] cfg_f,
  input  logic [PIX_W-1:0] cfg_m,
  input  logic [PIX_W-1:0] cfg_n,
  output logic             busy,
  chaos_diffusion_stream_if.slave bus
);

  localparam int DW = CHANNELS * PIX_W;
  localparam int SW = PIX_W + 3;
  localparam int FW = PIX_W + 1;
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] LAST_COL = CW'(IMG_W - 1);
  localparam logic [RW-1:0] LAST_ROW = RW'(IMG_H - 1);

  state_e           state, state_next;
  mode_e            mode_lat, mode_cur;
  logic [FW-1:0]    f_lat, f_cur, f_cfg;
  logic [PIX_W-1:0] m_lat, n_lat, m_cur, n_cur, m_cfg, n_cfg;
  logic [CW-1:0]    col;
  logic [RW-1:0]    row;
  logic [DW-1:0]    left_ref, up_ref, ref_data, out_data;
  logic [PIX_W-1:0] x_in, up_v, left_v, res_v;
  logic [SW-1:0]    term, raw;
  logic             accept, last_pix;

  assign bus.s_ready = !bus.m_valid || bus.m_ready;
  assign accept      = bus.s_valid && bus.s_ready;
  assign last_pix    = (row == LAST_ROW) && (col == LAST_COL);

  // The first pixel of a frame uses the live config; the rest of the frame uses the frozen copy
  always_comb begin
    f_cfg = (cfg_f == '0) ? FW'(1 << PIX_W) : {1'b0, cfg_f};
    m_cfg = PIX_W'({1'b0, cfg_m} % f_cfg);
    n_cfg = PIX_W'({1'b0, cfg_n} % f_cfg);
    if (state == S_IDLE) begin
      f_cur    = f_cfg;
      m_cur    = m_cfg;
      n_cur    = n_cfg;
      mode_cur = mode_e'(cfg_mode);
    end else begin
      f_cur    = f_lat;
      m_cur    = m_lat;
      n_cur    = n_lat;
      mode_cur = mode_lat;
    end
  end

  // Decrypt adds 3F before subtracting so the intermediate never goes negative
  always_comb begin
    ref_data = '0;
    out_data = '0;
    x_in     = '0;
    up_v     = '0;
    left_v   = '0;
    term     = '0;
    raw      = '0;
    res_v    = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      x_in   = PIX_W'({1'b0, bus.s_data[k*PIX_W +: PIX_W]} % f_cur);
      up_v   = up_ref[k*PIX_W +: PIX_W];
      left_v = left_ref[k*PIX_W +: PIX_W];
      if (row == '0 && col == '0) term = SW'(n_cur);
      else if (row == '0)         term = SW'(left_v);
      else if (col == '0)         term = SW'(up_v);
      else                        term = SW'(up_v) + SW'(left_v) + SW'(m_cur);
      if (mode_cur == MODE_ENC) raw = SW'(x_in) + term;
      else                      raw = SW'(x_in) + SW'(f_cur) + SW'(f_cur) + SW'(f_cur) - term;
      res_v = PIX_W'(mod_reduce(32'(raw), 32'(f_cur)));
      out_data[k*PIX_W +: PIX_W] = res_v;
      ref_data[k*PIX_W +: PIX_W] = (mode_cur == MODE_ENC) ? res_v : x_in;
    end
  end

  diffusion_line_buf #(.DEPTH(IMG_W), .DW(DW)) u_line_buf (
    .clk   (clk),
    .we    (accept),
    .addr  (col),
    .wdata (ref_data),
    .rdata (up_ref)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    case (state)
      S_IDLE: if (accept) state_next = S_RUN;
      S_RUN: begin
        busy = 1'b1;
        if (accept && last_pix) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  // Output register holds its contents whenever the sink stalls
  always_ff @(posedge clk) begin
    if (rst) begin
      row         <= '0;
      col         <= '0;
      left_ref    <= '0;
      mode_lat    <= MODE_DEC;
      f_lat       <= '0;
      m_lat       <= '0;
      n_lat       <= '0;
      bus.m_valid <= 1'b0;
      bus.m_data  <= '0;
      bus.m_sof   <= 1'b0;
      bus.m_eol   <= 1'b0;
      bus.m_eof   <= 1'b0;
    end else begin
      if (accept) begin
        left_ref    <= ref_data;
        bus.m_valid <= 1'b1;
        bus.m_data  <= out_data;
        bus.m_sof   <= (row == '0) && (col == '0);
        bus.m_eol   <= (col == LAST_COL);
        bus.m_eof   <= last_pix;
        if (col == LAST_COL) begin
          col <= '0;
          row <= (row == LAST_ROW) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
        if (state == S_IDLE) begin
          mode_lat <= mode_cur;
          f_lat    <= f_cfg;
          m_lat    <= m_cfg;
          n_lat    <= n_cfg;
        end
      end else if (bus.m_ready) begin
        bus.m_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_chaos_diffusion_stream.sv
// Directed self-checking bench for chaos_diffusion_stream (4x3 frame, 2 lanes of 8 bits).
module tb_chaos_diffusion_stream;

  localparam int CH   = 2;
  localparam int W    = 4;
  localparam int H    = 3;
  localparam int NPIX = W * H;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_mode;
  logic [7:0] cfg_f, cfg_m, cfg_n;
  logic       busy;

  chaos_diffusion_stream_if #(.DW(16)) bus ();

  chaos_diffusion_stream #(.PIX_W(8), .CHANNELS(CH), .IMG_W(W), .IMG_H(H)) dut (
    .clk      (clk),
    .rst      (rst),
    .cfg_mode (cfg_mode),
    .cfg_f    (cfg_f),
    .cfg_m    (cfg_m),
    .cfg_n    (cfg_n),
    .busy     (busy),
    .bus      (bus)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          passes = 0;
  logic [15:0] tx_pix [NPIX];
  logic [15:0] got    [NPIX];
  logic [2:0]  got_flags [NPIX];
  int          got_count, lat_err, stall_cycles, stall_data_err, stall_ready_err;
  int          model_in  [CH][NPIX];
  int          model_out [CH][NPIX];
  int          plain     [CH][NPIX];

  // Straight-line reference: true modulo arithmetic over a full frame array
  task automatic model_frame(input bit enc, input int f, input int m, input int n);
    int ff, mm, nn, x, t, y;
    int c [H][W];
    ff = (f == 0) ? 256 : f;
    mm = m % ff;
    nn = n % ff;
    for (int l = 0; l < CH; l++)
      for (int i = 0; i < H; i++)
        for (int j = 0; j < W; j++) begin
          x = model_in[l][i*W+j] % ff;
          if (i == 0 && j == 0) t = nn;
          else if (i == 0)      t = c[i][j-1];
          else if (j == 0)      t = c[i-1][j];
          else                  t = c[i-1][j] + c[i][j-1] + mm;
          if (enc) begin
            y = (x + t) % ff;
            c[i][j] = y;
          end else begin
            y = ((x - t) % ff + ff) % ff;
            c[i][j] = x;
          end
          model_out[l][i*W+j] = y;
        end
  endtask

  task automatic load_tx();
    for (int p = 0; p < NPIX; p++) tx_pix[p] = {8'(model_in[1][p]), 8'(model_in[0][p])};
  endtask

  task automatic random_input();
    for (int l = 0; l < CH; l++)
      for (int p = 0; p < NPIX; p++) model_in[l][p] = int'($urandom_range(250, 0));
  endtask

  task automatic do_reset();
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic set_cfg(input logic mode, input logic [7:0] f, input logic [7:0] m, input logic [7:0] n);
    cfg_mode = mode;
    cfg_f    = f;
    cfg_m    = m;
    cfg_n    = n;
  endtask

  // Drives n pixels and collects n outputs; optional sink stall and mid-frame cfg_m change
  task automatic stream_frame(input int n, input int stall_at, input int stall_len,
                              input int cfg_at, input logic [7:0] new_m);
    int sent, cyc, stall_left;
    bit stall_done;
    logic [15:0] held;
    sent = 0; cyc = 0; stall_left = 0; stall_done = 0; held = '0;
    got_count = 0; lat_err = 0; stall_cycles = 0; stall_data_err = 0; stall_ready_err = 0;
    while (got_count < n && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (!stall_done && stall_at >= 0 && got_count == stall_at && bus.m_valid) begin
        stall_left = stall_len;
        held       = bus.m_data;
        stall_done = 1;
      end
      if (stall_left > 0) begin
        bus.m_ready = 1'b0;
        stall_left--;
        stall_cycles++;
        if (bus.m_data !== held) stall_data_err++;
      end else begin
        bus.m_ready = 1'b1;
      end
      if (cfg_at >= 0 && sent == cfg_at) cfg_m = new_m;
      if (sent < n) begin
        bus.s_valid = 1'b1;
        bus.s_data  = tx_pix[sent];
      end else begin
        bus.s_valid = 1'b0;
      end
      #1;
      if (!bus.m_ready && bus.s_ready) stall_ready_err++;
      if (bus.m_valid && bus.m_ready) begin
        if (got_count != sent - 1) lat_err++;
        got[got_count]       = bus.m_data;
        got_flags[got_count] = {bus.m_sof, bus.m_eol, bus.m_eof};
        got_count++;
      end
      if (bus.s_valid && bus.s_ready) sent++;
    end
    bus.s_valid = 1'b0;
    bus.m_ready = 1'b1;
    checks++;
    if (got_count != n) $display("[TB] FAIL stream_timeout: got %0d outputs, required %0d", got_count, n);
    else passes++;
  endtask

  task automatic test_reset();
    do_reset();
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0) $display("[TB] FAIL reset_m_valid: got %b required 0", bus.m_valid);
    else passes++;
    checks++;
    if (bus.m_data !== 16'h0) $display("[TB] FAIL reset_m_data: got %h required 0000", bus.m_data);
    else passes++;
    checks++;
    if ({bus.m_sof, bus.m_eol, bus.m_eof} !== 3'b000)
      $display("[TB] FAIL reset_flags: got %b required 000", {bus.m_sof, bus.m_eol, bus.m_eof});
    else passes++;
    checks++;
    if (busy !== 1'b0) $display("[TB] FAIL reset_busy: got %b required 0", busy);
    else passes++;
    checks++;
    if (bus.s_ready !== 1'b1) $display("[TB] FAIL reset_s_ready: got %b required 1", bus.s_ready);
    else passes++;
  endtask

  // Decrypt of pixel (0,0): 10-3=7, 2-3 wraps to 250, 255 reduces to 4 then 4-3=1
  task automatic test_dec_first();
    set_cfg(1'b0, 8'd251, 8'd0, 8'd3);
    tx_pix[0] = {8'd2, 8'd10};
    stream_frame(1, -1, 0, -1, 8'd0);
    checks++;
    if (got[0] !== {8'd250, 8'd7}) $display("[TB] FAIL dec_first_data: got %h required %h", got[0], {8'd250, 8'd7});
    else passes++;
    checks++;
    if (got_flags[0] !== 3'b100) $display("[TB] FAIL dec_first_sof: got %b required 100", got_flags[0]);
    else passes++;
    checks++;
    if (busy !== 1'b1) $display("[TB] FAIL dec_first_busy: got %b required 1", busy);
    else passes++;
    checks++;
    if (lat_err != 0) $display("[TB] FAIL dec_first_latency: got %0d late outputs required 0", lat_err);
    else passes++;
    do_reset();
    tx_pix[0] = {8'd255, 8'd255};
    stream_frame(1, -1, 0, -1, 8'd0);
    checks++;
    if (got[0] !== {8'd1, 8'd1}) $display("[TB] FAIL dec_reduce_in: got %h required 0101", got[0]);
    else passes++;
    do_reset();
  endtask

  // F=0 means 256; interior (1,1): 5-100-50-200 mod 256 = 167
  task automatic test_dec_mod256();
    logic [15:0] exp;
    int lane0 [NPIX] = '{9, 100, 30, 40, 50, 5, 60, 70, 80, 90, 11, 12};
    for (int p = 0; p < NPIX; p++) begin
      model_in[0][p] = lane0[p];
      model_in[1][p] = (p * 37 + 13) % 256;
    end
    load_tx();
    set_cfg(1'b0, 8'd0, 8'd200, 8'd17);
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    checks++;
    if (got[5][7:0] !== 8'd167) $display("[TB] FAIL dec256_interior: got %0d required 167", got[5][7:0]);
    else passes++;
    model_frame(1'b0, 0, 200, 17);
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(model_out[1][p]), 8'(model_out[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL dec256_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
    end
  endtask

  task automatic test_roundtrip();
    logic [15:0] exp;
    random_input();
    plain = model_in;
    load_tx();
    set_cfg(1'b1, 8'd251, 8'd7, 8'd3);
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    model_frame(1'b1, 251, 7, 3);
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(model_out[1][p]), 8'(model_out[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL enc_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
      checks++;
      if (got[p][7:0] >= 8'd251 || got[p][15:8] >= 8'd251)
        $display("[TB] FAIL enc_range%0d: got %h required lanes below 251", p, got[p]);
      else passes++;
    end
    model_in = model_out;
    load_tx();
    set_cfg(1'b0, 8'd251, 8'd7, 8'd3);
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(plain[1][p]), 8'(plain[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL roundtrip_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
    end
  endtask

  task automatic test_backpressure();
    logic [15:0] exp;
    logic [2:0]  exp_flags;
    random_input();
    load_tx();
    set_cfg(1'b1, 8'd251, 8'd7, 8'd3);
    stream_frame(NPIX, 5, 5, -1, 8'd0);
    model_frame(1'b1, 251, 7, 3);
    checks++;
    if (stall_cycles != 5) $display("[TB] FAIL bp_stall_len: got %0d required 5", stall_cycles);
    else passes++;
    checks++;
    if (stall_data_err != 0) $display("[TB] FAIL bp_hold: got %0d changes required 0", stall_data_err);
    else passes++;
    checks++;
    if (stall_ready_err != 0) $display("[TB] FAIL bp_s_ready: got %0d ready cycles required 0", stall_ready_err);
    else passes++;
    checks++;
    if (lat_err != 0) $display("[TB] FAIL bp_order: got %0d out-of-step outputs required 0", lat_err);
    else passes++;
    for (int p = 0; p < NPIX; p++) begin
      exp       = {8'(model_out[1][p]), 8'(model_out[0][p])};
      exp_flags = {p == 0, (p % W) == W - 1, p == NPIX - 1};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL bp_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
      checks++;
      if (got_flags[p] !== exp_flags)
        $display("[TB] FAIL bp_flags%0d: got %b required %b", p, got_flags[p], exp_flags);
      else passes++;
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || bus.m_valid !== 1'b0)
      $display("[TB] FAIL bp_idle_after: got busy=%b m_valid=%b required 0 0", busy, bus.m_valid);
    else passes++;
  endtask

  task automatic test_cfg_change();
    logic [15:0] exp;
    random_input();
    load_tx();
    set_cfg(1'b1, 8'd251, 8'd7, 8'd3);
    stream_frame(NPIX, -1, 0, 6, 8'd9);
    model_frame(1'b1, 251, 7, 3);
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(model_out[1][p]), 8'(model_out[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL cfg_hold_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
    end
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    model_frame(1'b1, 251, 9, 3);
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(model_out[1][p]), 8'(model_out[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL cfg_next_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp;
    random_input();
    load_tx();
    set_cfg(1'b1, 8'd251, 8'd7, 8'd3);
    stream_frame(5, -1, 0, -1, 8'd0);
    @(negedge clk);
    rst         = 1'b1;
    bus.s_valid = 1'b1;
    bus.s_data  = tx_pix[5];
    @(negedge clk);
    checks++;
    if (bus.m_valid !== 1'b0 || bus.m_data !== 16'h0)
      $display("[TB] FAIL rstmid_out: got valid=%b data=%h required 0 0000", bus.m_valid, bus.m_data);
    else passes++;
    checks++;
    if ({bus.m_sof, bus.m_eol, bus.m_eof} !== 3'b000 || busy !== 1'b0)
      $display("[TB] FAIL rstmid_flags: got flags=%b busy=%b required 000 0",
               {bus.m_sof, bus.m_eol, bus.m_eof}, busy);
    else passes++;
    rst         = 1'b0;
    bus.s_valid = 1'b0;
    random_input();
    load_tx();
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    model_frame(1'b1, 251, 7, 3);
    checks++;
    if (got_flags[0] !== 3'b100) $display("[TB] FAIL rstmid_sof: got %b required 100", got_flags[0]);
    else passes++;
    for (int p = 0; p < NPIX; p++) begin
      exp = {8'(model_out[1][p]), 8'(model_out[0][p])};
      checks++;
      if (got[p] !== exp) $display("[TB] FAIL rstmid_pix%0d: got %h required %h", p, got[p], exp);
      else passes++;
    end
  endtask

  task automatic test_f_one();
    random_input();
    load_tx();
    set_cfg(1'b1, 8'd1, 8'd7, 8'd3);
    stream_frame(NPIX, -1, 0, -1, 8'd0);
    for (int p = 0; p < NPIX; p++) begin
      checks++;
      if (got[p] !== 16'h0) $display("[TB] FAIL f1_pix%0d: got %h required 0000", p, got[p]);
      else passes++;
    end
  endtask

  initial begin
    set_cfg(1'b0, 8'd0, 8'd0, 8'd0);
    rst         = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_data  = '0;
    bus.m_ready = 1'b1;
    test_reset();
    test_dec_first();
    test_dec_mod256();
    test_roundtrip();
    test_backpressure();
    test_cfg_change();
    test_reset_mid();
    test_f_one();
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
